// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - EX-stage to HI/LO multiply/divide sequencer bundle
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             mthi;
    logic             mtlo;
    logic             hilo_read;
    logic             flush;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall_req;

    modport master (
        output start, op, rs_data, rt_data, mthi, mtlo, hilo_read, flush,
        input  hi, lo, busy, done, stall_req
    );

    modport slave (
        input  start, op, rs_data, rt_data, mthi, mtlo, hilo_read, flush,
        output hi, lo, busy, done, stall_req
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               res_neg;
    logic               rem_neg;
    logic               div_zero;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign a_neg = !bus.op[0] && bus.rs_data[WIDTH-1];
    assign b_neg = !bus.op[0] && bus.rt_data[WIDTH-1];
    assign a_mag = a_neg ? -bus.rs_data : bus.rs_data;
    assign b_mag = b_neg ? -bus.rt_data : bus.rt_data;

    // acc holds {partial product, remaining multiplier} or {remainder, quotient}
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

    // A zero divisor leaves the dividend magnitude in the remainder; the
    // remainder sign restores the original rs_data, only the quotient needs forcing.
    assign prod_fix = res_neg ? -acc : acc;
    assign quo_fix  = div_zero ? '1 : (res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    assign rem_fix  = rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.mthi) hi_q <= bus.rs_data;
                    if (bus.mtlo) lo_q <= bus.rs_data;
                    if (bus.start && !bus.flush) begin
                        is_div   <= bus.op[1];
                        res_neg  <= a_neg ^ b_neg;
                        rem_neg  <= a_neg;
                        div_zero <= bus.op[1] && (bus.rt_data == '0);
                        opnd     <= bus.op[1] ? b_mag : a_mag;
                        acc      <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
                        cnt      <= CW'(WIDTH - 1);
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= is_div ? div_next : mul_next;
                        if (cnt == '0) state <= FIX;
                        else           cnt   <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    if (!bus.flush) begin
                        hi_q   <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                        lo_q   <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
                        done_q <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state != IDLE);
    assign bus.stall_req = bus.busy & (bus.hilo_read | bus.start | bus.mthi | bus.mtlo);
endmodule
